// File: rtl/gc_pkg.sv
// Shared definitions for the garbled-circuit control path: sequencer state
// encoding, widths and the captured gate descriptor layout.
package gc_pkg;

  localparam int GC_S    = 14;
  localparam int GC_CC_W = 16;
  localparam int P       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_FETCH,
    ST_ISSUE,
    ST_CYCLE_END,
    ST_DONE
  } gate_seq_state_t;

  typedef struct packed {
    logic [GC_S-1:0] in0;
    logic [GC_S-1:0] in1;
    logic            in0F;
    logic            in1F;
    logic [P-1:0]    g_logic;
    logic            is_output;
    logic [GC_S-1:0] out_wire;
    logic            last;
  } gate_desc_t;

endpackage

// File: rtl/gate_sequencer_if.sv
// Descriptor handshake between the gate sequencer (master) and the
// garbling core (slave).
interface gate_sequencer_if
  import gc_pkg::*;
#(
    parameter int S    = GC_S,
    parameter int CC_W = GC_CC_W
) ();

    logic            gate_valid;
    logic            gate_ready;
    logic [S-1:0]    g_in0;
    logic [S-1:0]    g_in1;
    logic            g_in0F;
    logic            g_in1F;
    logic [P-1:0]    g_logic;
    logic            g_is_output;
    logic [S-1:0]    g_out_wire;
    logic            g_last;
    logic [CC_W-1:0] cycle_idx;

    modport master (
        output gate_valid, g_in0, g_in1, g_in0F, g_in1F, g_logic,
               g_is_output, g_out_wire, g_last, cycle_idx,
        input  gate_ready
    );

    modport slave (
        input  gate_valid, g_in0, g_in1, g_in0F, g_in1F, g_logic,
               g_is_output, g_out_wire, g_last, cycle_idx,
        output gate_ready
    );

endinterface

// File: rtl/gate_desc_reg.sv
// Holding register for one gate descriptor: loads on capture, stays stable
// while the consumer applies backpressure, drops valid on acceptance.
module gate_desc_reg
  import gc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       ready,
    input  gate_desc_t d,
    output gate_desc_t q,
    output logic       valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gate_sequencer.sv
// Walks the netlist store once per circuit cycle, handing each gate
// descriptor to the garbling core and pacing the store's cycle preparation.
module gate_sequencer
  import gc_pkg::*;
#(
    parameter int S    = GC_S,
    parameter int CC_W = GC_CC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CC_W-1:0]     num_cycles,
    input  logic                nl_ready,
    input  logic signed [S-1:0] gate_size,
    input  logic [S-1:0]        wire_base,
    input  logic [S-1:0]        nl_in0,
    input  logic [S-1:0]        nl_in1,
    input  logic                nl_in0F,
    input  logic                nl_in1F,
    input  logic [P-1:0]        nl_g_logic,
    input  logic                nl_is_output,
    output logic [S-1:0]        rd_addr,
    output logic                prep_next_cycle,
    output logic                busy,
    output logic                done,
    gate_sequencer_if.master    gs
);

    gate_seq_state_t state_q, state_d;

    logic [S-1:0]    gate_idx;
    logic [CC_W-1:0] cycle_idx_q;
    logic [CC_W-1:0] nc_q;
    logic            capture;
    logic            accept;
    logic            cycle_last;
    logic            size_empty;
    logic            desc_valid;
    gate_desc_t      desc_d;
    gate_desc_t      desc_q;

    assign accept     = (state_q == ST_ISSUE) && gs.gate_ready;
    assign cycle_last = (cycle_idx_q == nc_q - 1'b1);
    assign size_empty = gate_size[S-1] || (gate_size == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (start) state_d = (num_cycles == '0) ? ST_DONE : ST_WAIT_RDY;
            ST_WAIT_RDY:  if (nl_ready) state_d = size_empty ? ST_CYCLE_END : ST_FETCH;
            ST_FETCH:     state_d = ST_ISSUE;
            ST_ISSUE:     if (accept) state_d = desc_q.last ? ST_CYCLE_END : ST_FETCH;
            ST_CYCLE_END: state_d = cycle_last ? ST_DONE : ST_WAIT_RDY;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prep_next_cycle = (state_q == ST_CYCLE_END);
        done            = (state_q == ST_DONE);
        busy            = (state_q != ST_IDLE);
        capture         = (state_q == ST_FETCH);
    end

    // rd_addr is the gate index itself; the store answers within the FETCH cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gate_idx    <= '0;
            cycle_idx_q <= '0;
            nc_q        <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) begin
                    nc_q        <= num_cycles;
                    cycle_idx_q <= '0;
                end
                ST_WAIT_RDY:  if (nl_ready) gate_idx <= '0;
                ST_ISSUE:     if (accept && !desc_q.last) gate_idx <= gate_idx + 1'b1;
                ST_CYCLE_END: if (!cycle_last) cycle_idx_q <= cycle_idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        desc_d           = '0;
        desc_d.in0       = nl_in0;
        desc_d.in1       = nl_in1;
        desc_d.in0F      = nl_in0F;
        desc_d.in1F      = nl_in1F;
        desc_d.g_logic   = nl_g_logic;
        desc_d.is_output = nl_is_output;
        desc_d.out_wire  = wire_base + gate_idx;
        desc_d.last      = (gate_idx == gate_size - 1'b1);
    end

    gate_desc_reg u_desc (
        .clk   (clk),
        .rst   (rst),
        .load  (capture),
        .ready (gs.gate_ready),
        .d     (desc_d),
        .q     (desc_q),
        .valid (desc_valid)
    );

    assign rd_addr        = gate_idx;
    assign gs.gate_valid  = desc_valid;
    assign gs.g_in0       = desc_q.in0;
    assign gs.g_in1       = desc_q.in1;
    assign gs.g_in0F      = desc_q.in0F;
    assign gs.g_in1F      = desc_q.in1F;
    assign gs.g_logic     = desc_q.g_logic;
    assign gs.g_is_output = desc_q.is_output;
    assign gs.g_out_wire  = desc_q.out_wire;
    assign gs.g_last      = desc_q.last;
    assign gs.cycle_idx   = cycle_idx_q;

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: scenario table plus hand-written multi-cycle
// sequences, against a combinational netlist-store model.
module tb_gate_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [15:0]        num_cycles;
    logic               nl_ready;
    logic signed [13:0] gate_size;
    logic [13:0]        wire_base;
    logic [13:0]        nl_in0, nl_in1;
    logic               nl_in0F, nl_in1F;
    logic [3:0]         nl_g_logic;
    logic               nl_is_output;
    logic [13:0]        rd_addr;
    logic               prep_next_cycle, busy, done;

    int n_vec = 0;
    int n_err = 0;

    gate_sequencer_if #(.S(14), .CC_W(16)) ifc ();

    gate_sequencer #(.S(14), .CC_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_cycles      (num_cycles),
        .nl_ready        (nl_ready),
        .gate_size       (gate_size),
        .wire_base       (wire_base),
        .nl_in0          (nl_in0),
        .nl_in1          (nl_in1),
        .nl_in0F         (nl_in0F),
        .nl_in1F         (nl_in1F),
        .nl_g_logic      (nl_g_logic),
        .nl_is_output    (nl_is_output),
        .rd_addr         (rd_addr),
        .prep_next_cycle (prep_next_cycle),
        .busy            (busy),
        .done            (done),
        .gs              (ifc)
    );

    always #5 clk = ~clk;

    // Store model: descriptor fields are simple functions of the address.
    always_comb begin
        nl_in0       = {rd_addr[12:0], 1'b1};
        nl_in1       = rd_addr + 14'd100;
        nl_in0F      = rd_addr[0];
        nl_in1F      = rd_addr[1];
        nl_g_logic   = rd_addr[3:0] ^ 4'h6;
        nl_is_output = rd_addr[2];
    end

    typedef struct {
        int gs;
        int nc;
        int wb;
        int dly;
        int mode;
        int exp_per;
        int exp_hs;
        int exp_prep;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [79:0] exp_desc(input int idx, input int cyc, input int gsz, input int wb);
        logic [13:0] i;
        logic [3:0]  lg;
        i  = 14'(idx);
        lg = i[3:0] ^ 4'h6;
        return {14'(idx * 2 + 1), 14'(idx + 100), i[0], i[1], lg, i[2],
                14'(wb + idx), (idx == gsz - 1), 16'(cyc), i};
    endfunction

    function automatic logic [79:0] act_desc();
        return {ifc.g_in0, ifc.g_in1, ifc.g_in0F, ifc.g_in1F, ifc.g_logic, ifc.g_is_output,
                ifc.g_out_wire, ifc.g_last, ifc.cycle_idx, rd_addr};
    endfunction

    task automatic run_scn(input vec_t v);
        int  gidx, cyc, hs, prep, hs_cyc, last_hs, last_prep, wcnt;
        bit  waiting, fin;
        gidx = 0; cyc = 0; hs = 0; prep = 0; hs_cyc = 0; last_hs = -1; last_prep = 0;
        wcnt = 0; waiting = 1; fin = 0;
        @(posedge clk); #1;
        num_cycles = 16'(v.nc); gate_size = 14'(v.gs); wire_base = 14'(v.wb);
        start = 1'b1; nl_ready = 1'b0; ifc.gate_ready = 1'b0;
        @(negedge clk);
        for (int k = 1; k < 400 && !fin; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            nl_ready = waiting && (wcnt == v.dly);
            if (nl_ready) waiting = 0;
            else if (waiting) wcnt++;
            ifc.gate_ready = (v.mode == 0) ? 1'b1 : ((k % 3) != 1);
            @(negedge clk);
            if (ifc.gate_valid && ifc.gate_ready) begin
                chk("desc", act_desc(), exp_desc(gidx, cyc, v.gs, v.wb));
                if (v.mode == 0 && last_hs >= 0) chk("spacing", k - last_hs, 2);
                last_hs = k; gidx++; hs++; hs_cyc++;
            end
            if (prep_next_cycle) begin
                chk("gates_per_cycle", hs_cyc, v.exp_per);
                prep++; cyc++; gidx = 0; hs_cyc = 0; last_hs = -1;
                waiting = 1; wcnt = 0; last_prep = k;
            end
            if (done) begin
                chk("done_gap", k - last_prep, 1);
                fin = 1;
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        nl_ready = 1'b0;
        chk("handshakes", hs, v.exp_hs);
        chk("prep_pulses", prep, v.exp_prep);
        @(negedge clk);
        chk("idle_after", {busy, done, ifc.gate_valid}, 3'b000);
    endtask

    vec_t vt[7];

    initial begin
        logic [79:0] snap;
        logic [13:0] ra0;
        int          hs, gidx;
        bit          fin;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [79:0] snap;
        logic [13:0] ra0;
        int          hs, gidx;
        bit          fin;

        vt[0] = '{gs: 3,  nc: 1, wb: 10,    dly: 0, mode: 0, exp_per: 3, exp_hs: 3, exp_prep: 1};
        vt[1] = '{gs: 2,  nc: 3, wb: 0,     dly: 5, mode: 0, exp_per: 2, exp_hs: 6, exp_prep: 3};
        vt[2] = '{gs: 6,  nc: 1, wb: 16380, dly: 1, mode: 0, exp_per: 6, exp_hs: 6, exp_prep: 1};
        vt[3] = '{gs: 0,  nc: 2, wb: 5,     dly: 2, mode: 0, exp_per: 0, exp_hs: 0, exp_prep: 2};
        vt[4] = '{gs: 4,  nc: 2, wb: 200,   dly: 3, mode: 1, exp_per: 4, exp_hs: 8, exp_prep: 2};
        vt[5] = '{gs: 1,  nc: 2, wb: 7,     dly: 0, mode: 1, exp_per: 1, exp_hs: 2, exp_prep: 2};
        vt[6] = '{gs: -3, nc: 1, wb: 0,     dly: 0, mode: 0, exp_per: 0, exp_hs: 0, exp_prep: 1};

        rst = 1'b0; start = 1'b0; num_cycles = '0; nl_ready = 1'b0;
        gate_size = '0; wire_base = '0; ifc.gate_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {busy, done, prep_next_cycle, ifc.gate_valid}, 4'b0000);
        chk("rst_rd_addr", rd_addr, 14'd0);
        chk("rst_cycle_idx", ifc.cycle_idx, 16'd0);
        chk("rst_desc", act_desc(), 80'd0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 7; i++) run_scn(vt[i]);

        // num_cycles = 0: IDLE, DONE, IDLE with no store activity
        ra0 = rd_addr;
        @(posedge clk); #1; num_cycles = '0; gate_size = 14'd3; start = 1'b1;
        @(negedge clk);
        chk("nc0_idle", {busy, done}, 2'b00);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("nc0_done", {busy, done, prep_next_cycle, ifc.gate_valid}, 4'b1100);
        chk("nc0_rd_addr", rd_addr, ra0);
        @(negedge clk);
        chk("nc0_back_idle", {busy, done}, 2'b00);

        // Backpressure on gate 0
        @(posedge clk); #1; num_cycles = 16'd1; gate_size = 14'd3; wire_base = 14'd50; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; nl_ready = 1'b1; ifc.gate_ready = 1'b0;
        @(posedge clk); #1; nl_ready = 1'b0;
        fin = 0;
        for (int k = 0; k < 10 && !fin; k++) begin
            @(negedge clk);
            if (ifc.gate_valid) fin = 1;
        end
        chk("bp_valid_seen", fin, 1'b1);
        snap = act_desc();
        chk("bp_desc0", snap, exp_desc(0, 0, 3, 50));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold", {ifc.gate_valid, act_desc()}, {1'b1, snap});
        end
        @(posedge clk); #1 ifc.gate_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", {ifc.gate_valid, act_desc()}, {1'b1, snap});
        hs = 1; gidx = 1; fin = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clk);
            if (ifc.gate_valid && ifc.gate_ready) begin
                chk("bp_desc", act_desc(), exp_desc(gidx, 0, 3, 50));
                gidx++; hs++;
            end
            if (done) fin = 1;
        end
        chk("bp_done", fin, 1'b1);
        chk("bp_handshakes", hs, 3);
        ifc.gate_ready = 1'b0;

        // Reset during ISSUE of gate 1
        @(posedge clk); #1; num_cycles = 16'd2; gate_size = 14'd3; wire_base = '0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; nl_ready = 1'b1; ifc.gate_ready = 1'b1;
        @(posedge clk); #1; nl_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; ifc.gate_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_issue1", {ifc.gate_valid, busy, rd_addr}, {2'b11, 14'd1});
        #2 rst = 1'b0;
        #1 chk("rst_async", {ifc.gate_valid, busy, rd_addr}, 16'd0);
        fin = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) fin = 1;
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) fin = 1;
        end
        chk("rst_no_done", fin, 1'b0);
        run_scn(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
